ext_bus_seq: RTL and testbench

EXT_BUS_SEQ -- requirements
Module: ext_bus_seq

---
 rtl/ext_bus_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 37 +++
 rtl/ext_bus_seq.sv | 158 +++++++++++++++
 tb/tb_ext_bus_seq.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_bus_pkg.sv
// Shared types and cartridge address map for the external bus sequencer.
package ext_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ALE  = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [15:0] ROM_END   = 16'h7FFF;
  localparam logic [15:0] CRAM_BASE = 16'hA000;
  localparam logic [15:0] CRAM_END  = 16'hBFFF;

  // Takes the address already normalised to 16 bits (upper bits of a wider bus).
  function automatic logic cart_hit(input logic [15:0] i_a16);
    return (i_a16 <= ROM_END) || ((i_a16 >= CRAM_BASE) && (i_a16 <= CRAM_END));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Single-grant arbiter: round-robin starting after i_ptr, or fixed lowest-index priority.
module rr_arbiter #(
  parameter int NCH    = 2,
  parameter int ARB_RR = 1,
  localparam int PW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0] i_req,
  input  logic [NCH-1:0] i_mask,
  input  logic [PW-1:0]  i_ptr,
  output logic           o_valid,
  output logic [NCH-1:0] o_grant
);

  logic [NCH-1:0] w_elig;
  int             w_start;
  int             w_bestDist;

  assign w_elig = i_req & ~i_mask;

  // Each eligible channel gets a distance from the search start; the nearest one wins.
  always_comb begin
    w_start    = (ARB_RR != 0) ? ((int'(i_ptr) + 1) % NCH) : 0;
    w_bestDist = NCH;
    for (int i = 0; i < NCH; i++) begin
      if (w_elig[i] && (((i + NCH - w_start) % NCH) < w_bestDist)) begin
        w_bestDist = (i + NCH - w_start) % NCH;
      end
    end
    o_grant = '0;
    for (int i = 0; i < NCH; i++) begin
      o_grant[i] = w_elig[i] && (((i + NCH - w_start) % NCH) == w_bestDist);
    end
  end

  assign o_valid = |o_grant;

endmodule

// File: rtl/ext_bus_seq.sv
// Multi-channel sequencer for a latched-address cartridge bus (ALE phase, then WAIT+1 data cycles).
module ext_bus_seq
  import ext_bus_pkg::*;
#(
  parameter int NCH    = 2,
  parameter int AW     = 16,
  parameter int DW     = 8,
  parameter int WAIT   = 0,
  parameter int ARB_RR = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    req,
  input  logic [NCH-1:0]    we,
  input  logic [NCH*AW-1:0] addr,
  input  logic [NCH*DW-1:0] wdata,
  output logic [NCH-1:0]    ack,
  output logic [DW-1:0]     rdata,
  output logic              busy,
  output logic [AW-1:0]     a,
  output logic [DW-1:0]     dout,
  input  logic [DW-1:0]     din,
  output logic              doe,
  output logic              wr,
  output logic              cale,
  output logic              cs
);

  localparam int         PW    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [2:0] WAIT3 = 3'(WAIT);

  state_t          r_state;
  state_t          w_nextState;
  logic [2:0]      r_wcnt;
  logic [PW-1:0]   r_ch;
  logic [PW-1:0]   r_ptr;
  logic [AW-1:0]   r_addr;
  logic            r_we;
  logic [DW-1:0]   r_wdata;
  logic [DW-1:0]   r_rdata;
  logic [NCH-1:0]  r_ack;

  logic [NCH-1:0]  w_mask;
  logic [NCH-1:0]  w_grant;
  logic [PW-1:0]   w_gidx;
  logic            w_gvalid;
  logic            w_final;
  logic            w_take;
  logic [15:0]     w_a16;
  logic            w_cart;

  assign w_final = (r_state == DATA) && (r_wcnt == WAIT3);
  assign w_take  = ((r_state == IDLE) || w_final) && w_gvalid;

  // The channel being finished is masked too, so a still-held req is not served twice.
  always_comb begin
    w_mask = r_ack;
    for (int i = 0; i < NCH; i++) begin
      if ((r_state == DATA) && (r_ch == PW'(i))) w_mask[i] = 1'b1;
    end
  end

  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_grant[i]) w_gidx = PW'(i);
    end
  end

  rr_arbiter #(
    .NCH    (NCH),
    .ARB_RR (ARB_RR)
  ) u_arb (
    .i_req   (req),
    .i_mask  (w_mask),
    .i_ptr   (r_ptr),
    .o_valid (w_gvalid),
    .o_grant (w_grant)
  );

  generate
    if (AW >= 16) begin : g_a16Wide
      assign w_a16 = r_addr[AW-1 -: 16];
    end else begin : g_a16Narrow
      assign w_a16 = {r_addr, {(16-AW){1'b0}}};
    end
  endgenerate

  assign w_cart = cart_hit(w_a16);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  // Pad outputs are decoded from the state alone, so reset drops them without waiting for a clock.
  always_comb begin
    w_nextState = r_state;
    a           = '0;
    cale        = 1'b0;
    wr          = 1'b0;
    doe         = 1'b0;
    cs          = 1'b0;
    dout        = '1;
    case (r_state)
      IDLE: begin
        if (w_gvalid) w_nextState = ALE;
      end
      ALE: begin
        w_nextState = DATA;
        a           = r_addr;
        cale        = 1'b1;
      end
      DATA: begin
        a   = r_addr;
        wr  = r_we;
        doe = r_we;
        cs  = w_cart;
        if (r_we) dout = r_wdata;
        if (w_final) w_nextState = w_gvalid ? ALE : IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wcnt  <= '0;
      r_ch    <= '0;
      r_ptr   <= PW'(NCH - 1);
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '1;
      r_ack   <= '0;
    end else begin
      r_ack <= '0;
      if ((r_state == DATA) && !w_final) r_wcnt <= r_wcnt + 3'd1;
      else                               r_wcnt <= '0;
      if (w_final) begin
        r_ack[r_ch] <= 1'b1;
        if (!r_we) r_rdata <= din;
      end
      if (w_take) begin
        r_ch    <= w_gidx;
        r_ptr   <= w_gidx;
        r_addr  <= addr[w_gidx*AW +: AW];
        r_we    <= we[w_gidx];
        r_wdata <= wdata[w_gidx*DW +: DW];
      end
    end
  end

  assign ack   = r_ack;
  assign rdata = r_rdata;
  assign busy  = (r_state != IDLE);

endmodule

// File: tb/tb_ext_bus_seq.sv
// Bench for ext_bus_seq: instance 0 is round-robin with WAIT=0, instance 1 is fixed priority with WAIT=2.
module tb_ext_bus_seq;

  localparam int NCH = 3;
  localparam int W0  = 0;
  localparam int W1  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req   [2];
  logic [2:0]  we    [2];
  logic [47:0] addr  [2];
  logic [23:0] wdata [2];
  logic [2:0]  ack   [2];
  logic [7:0]  rdata [2];
  logic [7:0]  dout  [2];
  logic [7:0]  din   [2];
  logic [15:0] a     [2];
  logic        busy  [2];
  logic        doe   [2];
  logic        wr    [2];
  logic        cale  [2];
  logic        cs    [2];
  int          nTests = 0;
  int          nFail  = 0;

  always #5 clk = ~clk;

  // External memory returns a simple function of the address it is handed.
  assign din[0] = a[0][7:0] ^ 8'h5A;
  assign din[1] = a[1][7:0] ^ 8'h5A;

  ext_bus_seq #(.NCH(NCH), .AW(16), .DW(8), .WAIT(W0), .ARB_RR(1)) u_rr (
    .clk(clk), .rst(rst), .req(req[0]), .we(we[0]), .addr(addr[0]), .wdata(wdata[0]),
    .ack(ack[0]), .rdata(rdata[0]), .busy(busy[0]), .a(a[0]), .dout(dout[0]), .din(din[0]),
    .doe(doe[0]), .wr(wr[0]), .cale(cale[0]), .cs(cs[0]));

  ext_bus_seq #(.NCH(NCH), .AW(16), .DW(8), .WAIT(W1), .ARB_RR(0)) u_fp (
    .clk(clk), .rst(rst), .req(req[1]), .we(we[1]), .addr(addr[1]), .wdata(wdata[1]),
    .ack(ack[1]), .rdata(rdata[1]), .busy(busy[1]), .a(a[1]), .dout(dout[1]), .din(din[1]),
    .doe(doe[1]), .wr(wr[1]), .cale(cale[1]), .cs(cs[1]));

  function automatic logic cartExp(input logic [15:0] ad);
    return (ad <= 16'h7FFF) || ((ad >= 16'hA000) && (ad <= 16'hBFFF));
  endfunction

  function automatic int pickWinner(input logic [2:0] r, input logic [2:0] m, input int last, input bit rr);
    int c;
    for (int k = 0; k < NCH; k++) begin
      c = rr ? ((last + 1 + k) % NCH) : k;
      if (r[c] && !m[c]) return c;
    end
    return -1;
  endfunction

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic applyStimulus(input int d, input int ch, input logic r, input logic w,
                               input logic [15:0] ad, input logic [7:0] wd);
    req[d][ch]            = r;
    we[d][ch]             = w;
    addr[d][ch*16 +: 16]  = ad;
    wdata[d][ch*8 +: 8]   = wd;
  endtask

  task automatic applyReset;
    tick;
    rst    = 1'b1;
    req[0] = '0;
    req[1] = '0;
    tick;
    rst    = 1'b0;
  endtask

  task automatic test_reset;
    for (int d = 0; d < 2; d++) begin
      req[d] = '0; we[d] = '0; addr[d] = '0; wdata[d] = '0;
    end
    rst = 1'b1;
    tick;
    tick;
    for (int d = 0; d < 2; d++) begin
      nTests++;
      if ({busy[d], cale[d], wr[d], doe[d], cs[d]} !== 5'b0) begin
        nFail++;
        $display("FAIL reset_ctrl dut%0d got %b exp 00000", d, {busy[d], cale[d], wr[d], doe[d], cs[d]});
      end
      nTests++;
      if ({ack[d], a[d], dout[d], rdata[d]} !== {3'b000, 16'h0000, 8'hFF, 8'hFF}) begin
        nFail++;
        $display("FAIL reset_data dut%0d got ack=%b a=%h dout=%h rdata=%h exp ack=000 a=0000 dout=ff rdata=ff",
                 d, ack[d], a[d], dout[d], rdata[d]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_single_read;
    applyStimulus(0, 0, 1'b1, 1'b0, 16'h4000, 8'h00);
    tick;
    nTests++;
    if ({cale[0], cs[0], a[0]} !== {1'b1, 1'b0, 16'h4000}) begin
      nFail++;
      $display("FAIL read_ale got cale=%b cs=%b a=%h exp cale=1 cs=0 a=4000", cale[0], cs[0], a[0]);
    end
    tick;
    nTests++;
    if ({cale[0], cs[0], wr[0], doe[0]} !== 4'b0100) begin
      nFail++;
      $display("FAIL read_data got cale/cs/wr/doe=%b exp 0100", {cale[0], cs[0], wr[0], doe[0]});
    end
    tick;
    nTests++;
    if ({ack[0], rdata[0], busy[0]} !== {3'b001, 8'h5A, 1'b0}) begin
      nFail++;
      $display("FAIL read_ack got ack=%b rdata=%h busy=%b exp ack=001 rdata=5a busy=0", ack[0], rdata[0], busy[0]);
    end
    req[0][0] = 1'b0;
    tick;
    nTests++;
    if ({ack[0], rdata[0]} !== {3'b000, 8'h5A}) begin
      nFail++;
      $display("FAIL read_hold got ack=%b rdata=%h exp ack=000 rdata=5a", ack[0], rdata[0]);
    end
  endtask

  task automatic test_write_wait;
    applyStimulus(1, 1, 1'b1, 1'b1, 16'hC123, 8'h3C);
    tick;
    nTests++;
    if ({cale[1], wr[1], doe[1], a[1]} !== {3'b100, 16'hC123}) begin
      nFail++;
      $display("FAIL write_ale got cale/wr/doe=%b a=%h exp 100 a=c123", {cale[1], wr[1], doe[1]}, a[1]);
    end
    for (int k = 1; k <= 3; k++) begin
      tick;
      nTests++;
      if ({wr[1], doe[1], cs[1], cale[1], dout[1], ack[1]} !== {4'b1100, 8'h3C, 3'b000}) begin
        nFail++;
        $display("FAIL write_data%0d got wr/doe/cs/cale=%b dout=%h ack=%b exp 1100 dout=3c ack=000",
                 k, {wr[1], doe[1], cs[1], cale[1]}, dout[1], ack[1]);
      end
    end
    tick;
    nTests++;
    if ({ack[1], rdata[1], wr[1], doe[1]} !== {3'b010, 8'hFF, 2'b00}) begin
      nFail++;
      $display("FAIL write_ack got ack=%b rdata=%h wr/doe=%b exp ack=010 rdata=ff wr/doe=00",
               ack[1], rdata[1], {wr[1], doe[1]});
    end
    req[1][1] = 1'b0;
    tick;
  endtask

  task automatic test_cart_boundary;
    logic [15:0] adTab [6] = '{16'h7FFF, 16'h8000, 16'h9FFF, 16'hA000, 16'hBFFF, 16'hC000};
    logic        csTab [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [7:0]  expRd;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 1'b1, 1'b0, adTab[i], 8'h00);
      tick;
      tick;
      nTests++;
      if (cs[0] !== csTab[i]) begin
        nFail++;
        $display("FAIL cart_cs_%h got %b exp %b", adTab[i], cs[0], csTab[i]);
      end
      tick;
      expRd = adTab[i][7:0] ^ 8'h5A;
      nTests++;
      if ({ack[0], rdata[0]} !== {3'b001, expRd}) begin
        nFail++;
        $display("FAIL cart_rd_%h got ack=%b rdata=%h exp ack=001 rdata=%h", adTab[i], ack[0], rdata[0], expRd);
      end
      req[0][0] = 1'b0;
      tick;
    end
  endtask

  task automatic test_round_robin;
    int got[$];
    int expOrd[6] = '{0, 1, 2, 0, 1, 2};
    int idleSeen = 0;
    applyReset;
    applyStimulus(0, 0, 1'b1, 1'b0, 16'h1000, 8'h00);
    applyStimulus(0, 1, 1'b1, 1'b0, 16'h2000, 8'h00);
    applyStimulus(0, 2, 1'b1, 1'b0, 16'h3000, 8'h00);
    for (int c = 0; c < 80 && got.size() < 6; c++) begin
      tick;
      if (busy[0] !== 1'b1) idleSeen++;
      for (int i = 0; i < NCH; i++) if (ack[0][i] === 1'b1) got.push_back(i);
    end
    nTests++;
    if (got.size() < 6) begin
      nFail++;
      $display("FAIL rr_timeout got %0d acks exp 6", got.size());
    end
    for (int i = 0; i < got.size() && i < 6; i++) begin
      nTests++;
      if (got[i] != expOrd[i]) begin
        nFail++;
        $display("FAIL rr_order%0d got ch%0d exp ch%0d", i, got[i], expOrd[i]);
      end
    end
    nTests++;
    if (idleSeen != 0) begin
      nFail++;
      $display("FAIL rr_gap got %0d idle cycles exp 0", idleSeen);
    end
    req[0] = '0;
    repeat (8) tick;
  endtask

  task automatic test_fixed_priority;
    int got[$];
    int expOrd[6] = '{0, 2, 0, 2, 0, 2};
    bit reraise0 = 1'b0;
    applyReset;
    applyStimulus(1, 0, 1'b1, 1'b0, 16'h0010, 8'h00);
    applyStimulus(1, 2, 1'b1, 1'b0, 16'h0030, 8'h00);
    for (int c = 0; c < 120 && got.size() < 6; c++) begin
      tick;
      if (reraise0) begin
        req[1][0] = 1'b1;
        reraise0  = 1'b0;
      end
      for (int i = 0; i < NCH; i++) if (ack[1][i] === 1'b1) got.push_back(i);
      if (ack[1][0] === 1'b1) begin
        nTests++;
        if ({cale[1], a[1]} !== {1'b1, 16'h0030}) begin
          nFail++;
          $display("FAIL fp_no_regrant got cale=%b a=%h exp cale=1 a=0030", cale[1], a[1]);
        end
        req[1][0] = 1'b0;
        reraise0  = 1'b1;
      end
    end
    nTests++;
    if (got.size() < 6) begin
      nFail++;
      $display("FAIL fp_timeout got %0d acks exp 6", got.size());
    end
    for (int i = 0; i < got.size() && i < 6; i++) begin
      nTests++;
      if (got[i] != expOrd[i]) begin
        nFail++;
        $display("FAIL fp_order%0d got ch%0d exp ch%0d", i, got[i], expOrd[i]);
      end
    end
    req[1] = '0;
    repeat (12) tick;
  endtask

  task automatic test_reset_mid_write;
    applyStimulus(1, 1, 1'b1, 1'b1, 16'hC000, 8'h11);
    tick;
    tick;
    nTests++;
    if (wr[1] !== 1'b1) begin
      nFail++;
      $display("FAIL rstmid_pre got wr=%b exp 1", wr[1]);
    end
    #2;
    rst = 1'b1;
    req[1][1] = 1'b0;
    #1;
    nTests++;
    if ({wr[1], doe[1], cale[1], busy[1], ack[1]} !== 7'b0) begin
      nFail++;
      $display("FAIL rstmid_async got wr/doe/cale/busy=%b ack=%b exp 0000 ack=000",
               {wr[1], doe[1], cale[1], busy[1]}, ack[1]);
    end
    applyStimulus(1, 0, 1'b1, 1'b0, 16'h0200, 8'h00);
    tick;
    tick;
    rst = 1'b0;
    tick;
    nTests++;
    if ({cale[1], a[1]} !== {1'b1, 16'h0200}) begin
      nFail++;
      $display("FAIL rstmid_restart got cale=%b a=%h exp cale=1 a=0200", cale[1], a[1]);
    end
    for (int k = 0; k < 3; k++) begin
      tick;
      nTests++;
      if (ack[1] !== 3'b000) begin
        nFail++;
        $display("FAIL rstmid_noack%0d got %b exp 000", k, ack[1]);
      end
    end
    tick;
    nTests++;
    if (ack[1] !== 3'b001) begin
      nFail++;
      $display("FAIL rstmid_ack got %b exp 001", ack[1]);
    end
    req[1][0] = 1'b0;
    tick;
  endtask

  // Transaction-level model: each grant yields one ALE cycle, WAIT+1 data cycles, then an ack cycle.
  task automatic test_random_traffic(input int d, input int ncyc);
    int          wt = (d == 0) ? W0 : W1;
    bit          rr = (d == 0);
    int          mCh = -1, mPh = 0, mAck = -1, mLast = NCH - 1, win, nAck;
    logic [15:0] mAddr = '0;
    logic        mWe = 1'b0;
    logic [7:0]  mWd = '0, mRd = 8'hFF;
    logic [2:0]  msk;
    bit          fin;
    logic [39:0] expV, gotV;
    applyReset;
    for (int c = 0; c < ncyc; c++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (req[d][ch] && (mAck == ch)) req[d][ch] = 1'b0;
        else if (!req[d][ch] && (mAck != ch) && ($urandom_range(0, 2) == 0))
          applyStimulus(d, ch, 1'b1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)),
                        8'($urandom_range(0, 255)));
      end
      fin = (mCh >= 0) && (mPh == wt + 1);
      msk = '0;
      if (mAck >= 0) msk[mAck] = 1'b1;
      if (fin) msk[mCh] = 1'b1;
      win  = ((mCh < 0) || fin) ? pickWinner(req[d], msk, mLast, rr) : -1;
      nAck = fin ? mCh : -1;
      if (fin && !mWe) mRd = mAddr[7:0] ^ 8'h5A;
      if ((mCh >= 0) && !fin) mPh++;
      else if (win >= 0) begin
        mCh = win; mPh = 0; mLast = win;
        mAddr = addr[d][win*16 +: 16];
        mWe   = we[d][win];
        mWd   = wdata[d][win*8 +: 8];
      end else mCh = -1;
      mAck = nAck;
      tick;
      expV = {1'b0, 3'b000, mRd, 16'h0000, 4'b0000, 8'hFF};
      if (mAck >= 0) expV[38:36] = 3'(1 << mAck);
      if (mCh >= 0) begin
        expV[39]    = 1'b1;
        expV[27:12] = mAddr;
        if (mPh == 0) expV[11:8] = 4'b1000;
        else begin
          expV[11:8] = {1'b0, mWe, mWe, cartExp(mAddr)};
          if (mWe) expV[7:0] = mWd;
        end
      end
      gotV = {busy[d], ack[d], rdata[d], a[d], cale[d], wr[d], doe[d], cs[d], dout[d]};
      nTests++;
      if (gotV !== expV) begin
        nFail++;
        $display("FAIL rand_dut%0d_cyc%0d got busy/ack/rdata/a/ctrl/dout=%h exp %h", d, c, gotV, expV);
      end
    end
    req[d] = '0;
    repeat (8) tick;
  endtask

  initial begin
    test_reset;
    test_single_read;
    test_write_wait;
    test_cart_boundary;
    test_round_robin;
    test_fixed_priority;
    test_reset_mid_write;
    test_random_traffic(0, 400);
    test_random_traffic(1, 400);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got no completion exp finish before 400000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
